// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - frame-buffer geometry, arbiter slot encoding and RGB field layout
package vga_pkg;

    localparam int FB_ADDR_W = 18;
    localparam int FB_DATA_W = 16;
    localparam int FB_WORDS  = 120000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DISP  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam int RGB_R_HI = 15;
    localparam int RGB_R_LO = 12;
    localparam int RGB_G_HI = 10;
    localparam int RGB_G_LO = 7;
    localparam int RGB_B_HI = 4;
    localparam int RGB_B_LO = 1;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } wbuf_entry_t;

    // Unused bit positions between the colour fields are left at zero.
    function automatic logic [FB_DATA_W-1:0] rgb_pack(input logic [3:0] r,
                                                      input logic [3:0] g,
                                                      input logic [3:0] b);
        logic [FB_DATA_W-1:0] px;
        px = '0;
        px[RGB_R_HI:RGB_R_LO] = r;
        px[RGB_G_HI:RGB_G_LO] = g;
        px[RGB_B_HI:RGB_B_LO] = b;
        return px;
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// rtl/wbuf_fifo.sv - synchronous write-buffer FIFO with occupancy count and full/empty flags
module wbuf_fifo #(
    parameter int WBUF_DEPTH = 4,
    parameter int W          = 34
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(WBUF_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(WBUF_DEPTH);

    logic [W-1:0]  mem [WBUF_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign rdata   = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - display/writer RAM-port arbiter; clear sweep enabled by VGA_FB_ARBITER_CLEAR_EN
module vga_fb_arbiter #(
`ifdef VGA_FB_ARBITER_CLEAR_EN
    parameter logic [15:0] CLR_COLOR = 16'h0000,
`endif
    parameter int FB_WORDS   = vga_pkg::FB_WORDS,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          pix_en,
    input  logic [vga_pkg::FB_ADDR_W-1:0] pix_addr,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [vga_pkg::FB_ADDR_W-1:0] wr_addr,
    input  logic [vga_pkg::FB_DATA_W-1:0] wr_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [vga_pkg::FB_ADDR_W-1:0] mem_addr,
    output logic [vga_pkg::FB_DATA_W-1:0] mem_din,
    output logic                          rd_valid,
`ifdef VGA_FB_ARBITER_CLEAR_EN
    input  logic                          clr_req,
    output logic                          clr_busy,
`endif
    output logic [7:0]                    drop_cnt
);

    import vga_pkg::*;

    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);

    logic [1:0]  slot;
    logic [1:0]  state_q;
    logic        ready_en;
    logic        fifo_full;
    logic        fifo_empty;
    logic        addr_bad;
    logic        push_any;
    logic        push_ok;
    wbuf_entry_t wentry;
    wbuf_entry_t head;

    assign wr_ready = ready_en && !fifo_full;
    assign addr_bad = (wr_addr > LAST_ADDR);
    assign push_any = wr_valid && wr_ready;
    assign push_ok  = push_any && !addr_bad;
    assign wentry   = '{addr: wr_addr, data: wr_data};

    wbuf_fifo #(
        .WBUF_DEPTH(WBUF_DEPTH),
        .W         ($bits(wbuf_entry_t))
    ) u_wbuf (
        .CLK  (CLK),
        .RST  (RST),
        .push (push_ok),
        .wdata(wentry),
        .pop  (slot == S_WRITE),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

`ifdef VGA_FB_ARBITER_CLEAR_EN
    logic [FB_ADDR_W-1:0] clr_addr;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            clr_busy <= 1'b0;
            clr_addr <= '0;
        end else if (!clr_busy && clr_req) begin
            clr_busy <= 1'b1;
            clr_addr <= '0;
        end else if (slot == S_CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                clr_busy <= 1'b0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end
`endif

    // Fresh decision every cycle; display never waits behind a write or sweep.
    always_comb begin
        slot = S_IDLE;
        if (pix_en) begin
            slot = S_DISP;
`ifdef VGA_FB_ARBITER_CLEAR_EN
        end else if (clr_busy) begin
            slot = S_CLEAR;
`endif
        end else if (!fifo_empty) begin
            slot = S_WRITE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            ready_en <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rd_valid <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state_q  <= slot;
            ready_en <= 1'b1;
            // state_q is one cycle behind the port; the RAM adds the second.
            rd_valid <= (state_q == S_DISP);
            mem_en   <= (slot != S_IDLE);
            mem_we   <= (slot == S_WRITE) || (slot == S_CLEAR);
            case (slot)
                S_DISP: begin
                    mem_addr <= pix_addr;
                end
                S_WRITE: begin
                    mem_addr <= head.addr;
                    mem_din  <= head.data;
                end
`ifdef VGA_FB_ARBITER_CLEAR_EN
                S_CLEAR: begin
                    mem_addr <= clr_addr;
                    mem_din  <= CLR_COLOR;
                end
`endif
                default: begin
                    mem_addr <= mem_addr;
                    mem_din  <= mem_din;
                end
            endcase
            if (push_any && addr_bad && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
